// File: rtl/pll_drp_pkg.sv
// Shared types and widths for the PLL DRP reconfiguration initiator.
// PLL_DRP_VERIFY_EN adds the post-write readback states.
package pll_drp_pkg;

    localparam int unsigned DRP_ADDR_W = 7;
    localparam int unsigned DRP_DATA_W = 16;

    typedef enum logic [3:0] {
        StIdle,
        StHold,
        StAccept,
        StRd,
        StRdWait,
        StWr,
        StWrWait,
`ifdef PLL_DRP_VERIFY_EN
        StVerify,
        StVerifyWait,
`endif
        StLockWait
    } state_e;

    // Mask bit 1 takes the new value, 0 keeps the readback bit.
    function automatic logic [DRP_DATA_W-1:0] rmw_merge(
        input logic [DRP_DATA_W-1:0] rdbk,
        input logic [DRP_DATA_W-1:0] mask,
        input logic [DRP_DATA_W-1:0] data
    );
        return (rdbk & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/drp_timer.sv
// Loadable down-counter; expired is high on the load_val-th enabled cycle after load.
// Unaffected by PLL_DRP_VERIFY_EN.
module drp_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired = en && (count_q == WIDTH'(1));

endmodule

// File: rtl/pll_drp_reconfig.sv
// DRP read-modify-write sequencer for one PLL: holds PLL reset across the update
// stream, then waits for lock. PLL_DRP_VERIFY_EN adds a readback check after each write.
module pll_drp_reconfig
    import pll_drp_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 8,
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic                  DCLK,
    input  logic                  RST_N,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [DRP_ADDR_W-1:0] REQ_ADDR,
    input  logic [DRP_DATA_W-1:0] REQ_MASK,
    input  logic [DRP_DATA_W-1:0] REQ_DATA,
    input  logic                  REQ_LAST,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [DRP_ADDR_W-1:0] DADDR,
    output logic                  DEN,
    output logic                  DWE,
    output logic [DRP_DATA_W-1:0] DI,
    input  logic [DRP_DATA_W-1:0] DO,
    input  logic                  DRDY,
    output logic                  PLL_RST,
    input  logic                  LOCKED
);

    localparam int unsigned RST_W  = $clog2(RST_CYCLES + 1);
    localparam int unsigned DRDY_W = $clog2(DRDY_TIMEOUT + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT + 1);

    // The RD/WR cycle itself counts toward the DRDY budget, so the wait timer gets one less.
    localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(RST_CYCLES);
    localparam logic [DRDY_W-1:0] DRDY_LOAD =
        DRDY_W'((DRDY_TIMEOUT > 1) ? DRDY_TIMEOUT - 1 : 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_TIMEOUT);

    state_e state_q, state_d, after_wr;

    logic [DRP_ADDR_W-1:0] addr_q;
    logic [DRP_DATA_W-1:0] mask_q, data_q, rdbk_q, wr_data;
    logic                  last_q, error_q, done_q, pll_rst_q;

    logic latch, capture, err_set, err_clr, done_set, pll_rst_d;
    logic hold_load, hold_en, hold_exp;
    logic drdy_load, drdy_en, drdy_exp;
    logic lock_load, lock_en, lock_exp;

    assign wr_data = rmw_merge(rdbk_q, mask_q, data_q);

    drp_timer #(.WIDTH(RST_W)) u_hold_timer (
        .clk      (DCLK),
        .rst_n    (RST_N),
        .load     (hold_load),
        .load_val (RST_LOAD),
        .en       (hold_en),
        .expired  (hold_exp)
    );

    drp_timer #(.WIDTH(DRDY_W)) u_drdy_timer (
        .clk      (DCLK),
        .rst_n    (RST_N),
        .load     (drdy_load),
        .load_val (DRDY_LOAD),
        .en       (drdy_en),
        .expired  (drdy_exp)
    );

    drp_timer #(.WIDTH(LOCK_W)) u_lock_timer (
        .clk      (DCLK),
        .rst_n    (RST_N),
        .load     (lock_load),
        .load_val (LOCK_LOAD),
        .en       (lock_en),
        .expired  (lock_exp)
    );

    always_comb begin
        state_d   = state_q;
        after_wr  = last_q ? StLockWait : StAccept;
        latch     = 1'b0;
        capture   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        done_set  = 1'b0;
        hold_load = 1'b0;
        drdy_load = 1'b0;
        lock_load = 1'b0;
        hold_en   = 1'b0;
        drdy_en   = 1'b0;
        lock_en   = 1'b0;
        REQ_READY = 1'b0;
        DEN       = 1'b0;
        DWE       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (REQ_VALID) begin
                    state_d   = StHold;
                    hold_load = 1'b1;
                    err_clr   = 1'b1;
                end
            end
            StHold: begin
                hold_en = 1'b1;
                if (hold_exp) state_d = StAccept;
            end
            StAccept: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    latch   = 1'b1;
                    state_d = StRd;
                end
            end
            StRd: begin
                DEN       = 1'b1;
                drdy_load = 1'b1;
                state_d   = StRdWait;
            end
            StRdWait: begin
                drdy_en = 1'b1;
                // DRDY wins over a coincident timeout.
                if (DRDY) begin
                    capture = 1'b1;
                    state_d = StWr;
                end else if (drdy_exp) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end
            end
            StWr: begin
                DEN       = 1'b1;
                DWE       = 1'b1;
                drdy_load = 1'b1;
                state_d   = StWrWait;
            end
            StWrWait: begin
                drdy_en = 1'b1;
                if (DRDY) begin
`ifdef PLL_DRP_VERIFY_EN
                    state_d = StVerify;
`else
                    state_d   = after_wr;
                    lock_load = last_q;
`endif
                end else if (drdy_exp) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end
            end
`ifdef PLL_DRP_VERIFY_EN
            StVerify: begin
                DEN       = 1'b1;
                drdy_load = 1'b1;
                state_d   = StVerifyWait;
            end
            StVerifyWait: begin
                drdy_en = 1'b1;
                if (DRDY) begin
                    if (DO != wr_data) begin
                        err_set = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d   = after_wr;
                        lock_load = last_q;
                    end
                end else if (drdy_exp) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end
            end
`endif
            StLockWait: begin
                lock_en = 1'b1;
                if (LOCKED) begin
                    done_set = 1'b1;
                    state_d  = StIdle;
                end else if (lock_exp) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        pll_rst_d = !(state_d inside {StIdle, StLockWait});
    end

    always_ff @(posedge DCLK) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            rdbk_q    <= '0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            pll_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_set;
            pll_rst_q <= pll_rst_d;
            if (latch) begin
                addr_q <= REQ_ADDR;
                mask_q <= REQ_MASK;
                data_q <= REQ_DATA;
                last_q <= REQ_LAST;
            end
            if (capture) rdbk_q <= DO;
            if (err_set) begin
                error_q <= 1'b1;
            end else if (err_clr) begin
                error_q <= 1'b0;
            end
        end
    end

    assign BUSY    = (state_q != StIdle);
    assign DONE    = done_q;
    assign ERROR   = error_q;
    assign PLL_RST = pll_rst_q;
    assign DADDR   = addr_q;
    assign DI      = wr_data;

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Directed bench for pll_drp_reconfig with a DRP/lock responder and an access scoreboard.
// Expectations follow PLL_DRP_VERIFY_EN when it is defined.
module tb_pll_drp_reconfig;
    import pll_drp_pkg::*;

    localparam int unsigned RST_CYCLES   = 8;
    localparam int unsigned DRDY_TIMEOUT = 64;
    localparam int unsigned LOCK_TIMEOUT = 4096;
`ifdef PLL_DRP_VERIFY_EN
    localparam int ACC    = 3;
    localparam bit VERIFY = 1'b1;
`else
    localparam int ACC    = 2;
    localparam bit VERIFY = 1'b0;
`endif

    logic        DCLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID, REQ_READY, REQ_LAST;
    logic [6:0]  REQ_ADDR;
    logic [15:0] REQ_MASK, REQ_DATA;
    logic        BUSY, DONE, ERROR, DEN, DWE, PLL_RST;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO = 16'h0;
    logic        DRDY = 1'b0;
    logic        LOCKED = 1'b0;

    always #5 DCLK = ~DCLK;

    pll_drp_reconfig #(
        .RST_CYCLES   (RST_CYCLES),
        .DRDY_TIMEOUT (DRDY_TIMEOUT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .DCLK      (DCLK),
        .RST_N     (RST_N),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_MASK  (REQ_MASK),
        .REQ_DATA  (REQ_DATA),
        .REQ_LAST  (REQ_LAST),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERROR     (ERROR),
        .DADDR     (DADDR),
        .DEN       (DEN),
        .DWE       (DWE),
        .DI        (DI),
        .DO        (DO),
        .DRDY      (DRDY),
        .PLL_RST   (PLL_RST),
        .LOCKED    (LOCKED)
    );

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } acc_t;

    acc_t exp_q[$];
    acc_t mon_e;

    int vectors = 0, miscompares = 0;
    int den_cnt = 0, done_cnt = 0, rst_falls = 0;
    int cyc = 0, den_cyc = 0, err_cyc = 0, fall_cyc = 0;
    bit no_drdy = 1'b0, corrupt = 1'b0, lock_en = 1'b1;
    logic prev_rst = 1'b0, prev_err = 1'b0;

    function automatic logic [15:0] init_val(input logic [6:0] a);
        return (a == 7'h08) ? 16'hABCD : {a, ~a, 2'b10};
    endfunction

    // Responder register file: DRDY three cycles after DEN.
    logic [15:0] mem [128];
    bit   [127:0] mem_wr;
    int          rsp_cnt = 0;
    logic [6:0]  rsp_addr = 7'h0;

    always @(posedge DCLK) begin
        DRDY <= 1'b0;
        if (rsp_cnt != 0) begin
            rsp_cnt <= rsp_cnt - 1;
            if (rsp_cnt == 1) begin
                DRDY <= 1'b1;
                DO   <= (mem_wr[rsp_addr] ? mem[rsp_addr] : init_val(rsp_addr))
                        ^ {15'h0, corrupt};
            end
        end
        if (DEN === 1'b1 && !no_drdy) begin
            rsp_cnt  <= 2;
            rsp_addr <= DADDR;
            if (DWE) begin
                mem[DADDR]    <= DI;
                mem_wr[DADDR] <= 1'b1;
            end
        end
    end

    int lock_cnt = 0;
    always @(posedge DCLK) begin
        cyc <= cyc + 1;
        if (PLL_RST === 1'b1 || !lock_en) begin
            lock_cnt <= 0;
            LOCKED   <= 1'b0;
        end else if (!LOCKED) begin
            lock_cnt <= lock_cnt + 1;
            if (lock_cnt == 19) LOCKED <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge DCLK) begin
        if (RST_N === 1'b1) begin
            if (DEN === 1'b1) begin
                den_cnt <= den_cnt + 1;
                den_cyc <= cyc;
                check("den_with_pll_rst", {31'h0, PLL_RST}, 32'h1);
                check("den_expected", {31'h0, exp_q.size() != 0}, 32'h1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("drp_we", {31'h0, DWE}, {31'h0, mon_e.we});
                    check("drp_addr", {25'h0, DADDR}, {25'h0, mon_e.addr});
                    if (mon_e.we) check("drp_di", {16'h0, DI}, {16'h0, mon_e.di});
                end
            end
            if (DONE === 1'b1) done_cnt <= done_cnt + 1;
            if (prev_rst && !PLL_RST) begin
                rst_falls <= rst_falls + 1;
                fall_cyc  <= cyc;
            end
            if (ERROR && !prev_err) err_cyc <= cyc;
        end
        prev_rst <= PLL_RST;
        prev_err <= ERROR;
    end

    // Reference register contents as the bench expects them after each write.
    logic [15:0] mdl [128];
    bit   [127:0] mdl_wr;

    task automatic push_entry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                              input bit corrupt_rd);
        logic [15:0] cur, wd;
        cur = mdl_wr[a] ? mdl[a] : init_val(a);
        if (corrupt_rd) cur = cur ^ 16'h0001;
        wd = (cur & ~m) | (d & m);
        mdl[a]    = wd;
        mdl_wr[a] = 1'b1;
        exp_q.push_back({1'b0, a, 16'h0});
        exp_q.push_back({1'b1, a, wd});
        if (VERIFY) exp_q.push_back({1'b0, a, 16'h0});
    endtask

    task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                        input logic l, output bit ok);
        REQ_VALID = 1'b1;
        REQ_ADDR  = a;
        REQ_MASK  = m;
        REQ_DATA  = d;
        REQ_LAST  = l;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge DCLK);
            if (REQ_READY) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge DCLK);
        #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit got_done, output bit got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge DCLK);
            if (DONE) begin
                got_done = 1'b1;
                break;
            end
            if (ERROR) begin
                got_err = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge DCLK);
    endtask

    logic [6:0]  t2_a [3];
    logic [15:0] t2_m [3];
    logic [15:0] t2_d [3];

    initial begin
        bit ok, gd, ge, seen;
        int d0, n0, f0;
        t2_a = '{7'h08, 7'h09, 7'h14};
        t2_m = '{16'hFF00, 16'hFFFF, 16'h0F0F};
        t2_d = '{16'h5500, 16'hC3C3, 16'h1234};
        REQ_VALID = 1'b0;
        REQ_ADDR  = '0;
        REQ_MASK  = '0;
        REQ_DATA  = '0;
        REQ_LAST  = 1'b0;
        RST_N     = 1'b0;
        repeat (3) @(posedge DCLK);
        @(negedge DCLK);
        check("reset_outputs", {2'b0, REQ_READY, BUSY, DONE, ERROR, DEN, DWE, PLL_RST, DADDR, DI},
              32'h0);
        @(posedge DCLK);
        #1 RST_N = 1'b1;
        repeat (2) @(posedge DCLK);
        #1;

        // 1: single entry, readback ABCD -> write AB34
        d0 = den_cnt; n0 = done_cnt;
        push_entry(7'h08, 16'h00FF, 16'h1234, 1'b0);
        send(7'h08, 16'h00FF, 16'h1234, 1'b1, ok);
        check("t1_accept", {31'h0, ok}, 32'h1);
        wait_end(300, gd, ge);
        check("t1_done", {30'h0, gd, ge}, 32'h2);
        check("t1_den_count", den_cnt - d0, ACC);
        check("t1_done_count", done_cnt - n0, 1);
        check("t1_error", {31'h0, ERROR}, 32'h0);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: three entries, PLL reset held throughout
        d0 = den_cnt; n0 = done_cnt; f0 = rst_falls;
        for (int i = 0; i < 3; i++) begin
            push_entry(t2_a[i], t2_m[i], t2_d[i], 1'b0);
            send(t2_a[i], t2_m[i], t2_d[i], (i == 2), ok);
            check("t2_accept", {31'h0, ok}, 32'h1);
        end
        wait_end(300, gd, ge);
        check("t2_done", {30'h0, gd, ge}, 32'h2);
        check("t2_den_count", den_cnt - d0, 3 * ACC);
        check("t2_done_count", done_cnt - n0, 1);
        check("t2_pll_rst_falls", rst_falls - f0, 1);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: DRDY never arrives
        no_drdy = 1'b1;
        d0 = den_cnt; n0 = done_cnt;
        exp_q.push_back({1'b0, 7'h0A, 16'h0});
        send(7'h0A, 16'hFFFF, 16'h0001, 1'b1, ok);
        wait_end(300, gd, ge);
        check("t3_error", {30'h0, gd, ge}, 32'h1);
        check("t3_error_latency", err_cyc - den_cyc, DRDY_TIMEOUT);
        check("t3_outputs", {29'h0, PLL_RST, BUSY, ERROR}, 32'h1);
        check("t3_den_count", den_cnt - d0, 1);
        check("t3_no_done", done_cnt - n0, 0);
        no_drdy = 1'b0;

        // 4: lock timeout, then a clean retry
        lock_en = 1'b0;
        n0 = done_cnt;
        push_entry(7'h10, 16'h00F0, 16'h00A0, 1'b0);
        send(7'h10, 16'h00F0, 16'h00A0, 1'b1, ok);
        wait_end(LOCK_TIMEOUT + 300, gd, ge);
        check("t4_lock_error", {30'h0, gd, ge}, 32'h1);
        check("t4_lock_latency", err_cyc - fall_cyc, LOCK_TIMEOUT);
        check("t4_no_done", done_cnt - n0, 0);
        lock_en = 1'b1;
        push_entry(7'h11, 16'hFFFF, 16'hBEEF, 1'b0);
        send(7'h11, 16'hFFFF, 16'hBEEF, 1'b1, ok);
        check("t4_error_cleared", {31'h0, ERROR}, 32'h0);
        wait_end(300, gd, ge);
        check("t4_retry_done", {30'h0, gd, ge}, 32'h2);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: reset during RD_WAIT, late DRDY must be ignored
        d0 = den_cnt;
        exp_q.push_back({1'b0, 7'h12, 16'h0});
        send(7'h12, 16'hFFFF, 16'h0000, 1'b1, ok);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge DCLK);
            if (DEN) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_den_seen", {31'h0, seen}, 32'h1);
        @(posedge DCLK);
        #1 RST_N = 1'b0;
        @(posedge DCLK);
        #1 RST_N = 1'b1;
        @(negedge DCLK);
        check("t5_reset_outputs",
              {2'b0, REQ_READY, BUSY, DONE, ERROR, DEN, DWE, PLL_RST, DADDR, DI}, 32'h0);
        repeat (10) @(negedge DCLK);
        check("t5_idle_after_drdy", {30'h0, BUSY, DEN}, 32'h0);
        check("t5_den_count", den_cnt - d0, 1);
        push_entry(7'h13, 16'h3C3C, 16'hFFFF, 1'b0);
        send(7'h13, 16'h3C3C, 16'hFFFF, 1'b1, ok);
        wait_end(300, gd, ge);
        check("t5_new_seq_done", {30'h0, gd, ge}, 32'h2);

        // 6: corrupted readback bit 0
        corrupt = 1'b1;
        n0 = done_cnt;
        push_entry(7'h20, 16'hF0F0, 16'h1234, 1'b1);
        send(7'h20, 16'hF0F0, 16'h1234, 1'b1, ok);
        wait_end(300, gd, ge);
`ifdef PLL_DRP_VERIFY_EN
        check("t6_verify_error", {30'h0, gd, ge}, 32'h1);
        check("t6_no_done", done_cnt - n0, 0);
`else
        check("t6_done", {30'h0, gd, ge}, 32'h2);
        check("t6_done_count", done_cnt - n0, 1);
`endif
        corrupt = 1'b0;
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
